// File: rtl/multi_timer.sv
// multi_timer: NumChannels independent prescaled up-counters behind a RISC-V style
// CSR window, each with a sticky interrupt that fires when its counter reaches top.

module multi_timer_channel #(
    parameter int CounterWidth = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ctrl_wr,
    input  logic [31:0]             wr_data,
    input  logic                    int_clear,
    output logic [31:0]             ctrl_rd,
    output logic [CounterWidth-1:0] count,
    output logic                    int_set
);
    localparam logic [31:0] TopMask  = (32'd1 << CounterWidth) - 32'd1;
    localparam logic [31:0] CtrlMask = (TopMask << 16) | 32'h0000_003F;

    logic                    enable;
    logic                    mode;
    logic [3:0]              pexp;
    logic [CounterWidth-1:0] top;
    logic [15:0]             psc;
    logic [15:0]             psc_mask;
    logic                    tick;
    logic                    fire;
    logic                    unused_wr;

    // Prescaler wraps at 2^P-1, so the tick lands on the last cycle of each period.
    assign psc_mask  = (16'd1 << pexp) - 16'd1;
    assign tick      = enable && (psc == psc_mask);
    assign fire      = tick && (count == top);
    assign unused_wr = ^(wr_data & ~CtrlMask);

    always_comb begin
        ctrl_rd                   = '0;
        ctrl_rd[0]                = enable;
        ctrl_rd[1]                = mode;
        ctrl_rd[5:2]              = pexp;
        ctrl_rd[16 +: CounterWidth] = top;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            enable  <= 1'b0;
            mode    <= 1'b0;
            pexp    <= '0;
            top     <= '0;
            psc     <= '0;
            count   <= '0;
            int_set <= 1'b0;
        end else begin
            int_set <= fire | (int_set & ~int_clear);
            // A ctrl write overrides any same-edge counting or one-shot disable.
            if (ctrl_wr) begin
                enable <= wr_data[0];
                mode   <= wr_data[1];
                pexp   <= wr_data[5:2];
                top    <= wr_data[16 +: CounterWidth];
                psc    <= '0;
                count  <= '0;
            end else if (enable) begin
                psc <= tick ? 16'd0 : psc + 16'd1;
                if (tick) begin
                    if (count == top) begin
                        count <= '0;
                        if (mode) enable <= 1'b0;
                    end else begin
                        count <= count + CounterWidth'(1);
                    end
                end
            end
        end
    end
endmodule

module multi_timer #(
    parameter int          NumChannels  = 4,
    parameter int          CounterWidth = 16,
    parameter logic [11:0] BaseAddr     = 12'h400
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   csr_enable,
    input  logic [11:0]            csr_addr,
    input  logic [2:0]             csr_op,
    input  logic [4:0]             rs1_zimm,
    input  logic [31:0]            rs1_data,
    input  logic [NumChannels-1:0] interrupt_clear,
    output logic [NumChannels-1:0] interrupt_set,
    output logic [31:0]            csr_out
);
    typedef struct packed {
        logic       hit;
        logic       is_count;
        logic [2:0] ch;
    } csr_dec_t;

    logic [11:0]                              offset;
    csr_dec_t                                 dec;
    logic [NumChannels-1:0][31:0]             ctrl_rd;
    logic [NumChannels-1:0][CounterWidth-1:0] count;
    logic [NumChannels-1:0]                   ctrl_wr;
    logic [31:0]                              sel_ctrl;
    logic [31:0]                              operand;
    logic [31:0]                              wr_data;
    logic                                     do_write;

    // Modular subtract: addresses below BaseAddr wrap high and miss the window.
    assign offset       = csr_addr - BaseAddr;
    assign dec.hit      = offset < 12'(2 * NumChannels);
    assign dec.is_count = offset[0];
    assign dec.ch       = offset[3:1];

    always_comb begin
        csr_out  = '0;
        sel_ctrl = '0;
        for (int ch = 0; ch < NumChannels; ch++) begin
            if (dec.hit && dec.ch == 3'(ch)) begin
                sel_ctrl = ctrl_rd[ch];
                csr_out  = dec.is_count ? 32'(count[ch]) : ctrl_rd[ch];
            end
        end
    end

    assign operand = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;

    // Set/clear with a zero operand is a pure read and must not restart the channel.
    always_comb begin
        do_write = 1'b0;
        wr_data  = '0;
        case (csr_op[1:0])
            2'b01: begin
                do_write = 1'b1;
                wr_data  = operand;
            end
            2'b10: begin
                do_write = |operand;
                wr_data  = sel_ctrl | operand;
            end
            2'b11: begin
                do_write = |operand;
                wr_data  = sel_ctrl & ~operand;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int ch = 0; ch < NumChannels; ch++) begin
            ctrl_wr[ch] = csr_enable && do_write && dec.hit && !dec.is_count
                          && dec.ch == 3'(ch);
        end
    end

    multi_timer_channel #(.CounterWidth(CounterWidth)) u_ch [NumChannels-1:0] (
        .clk       (clk),
        .reset     (reset),
        .ctrl_wr   (ctrl_wr),
        .wr_data   (wr_data),
        .int_clear (interrupt_clear),
        .ctrl_rd   (ctrl_rd),
        .count     (count),
        .int_set   (interrupt_set)
    );
endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: arithmetic reference model (tick/fire derived from elapsed
// enabled cycles), per-cycle compare, directed scenarios plus random CSR traffic.
module tb_multi_timer;
    localparam int          N     = 4;
    localparam int          CW    = 16;
    localparam logic [11:0] BASE  = 12'h400;
    localparam logic [31:0] CMASK = 32'hFFFF_003F;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          csr_enable = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic [2:0]    csr_op = '0;
    logic [4:0]    rs1_zimm = '0;
    logic [31:0]   rs1_data = '0;
    logic [N-1:0]  interrupt_clear = '0;
    logic [N-1:0]  interrupt_set;
    logic [31:0]   csr_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_timer #(.NumChannels(N), .CounterWidth(CW), .BaseAddr(BASE)) dut (
        .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
        .interrupt_clear(interrupt_clear), .interrupt_set(interrupt_set), .csr_out(csr_out)
    );

    // Model: ctrl word plus enabled cycles since last ctrl write; ticks = cyc / 2^P,
    // counter = ticks mod (top+1), a fire is any tick making ticks a multiple of top+1.
    logic [31:0]  m_ctrl [N];
    longint       m_cyc  [N];
    logic [N-1:0] m_int;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int off = int'(a) - int'(BASE);
        int ch, p;
        longint top;
        if (off < 0 || off >= 2 * N) return 32'd0;
        ch = off / 2;
        if (off % 2 == 0) return m_ctrl[ch];
        p   = int'(m_ctrl[ch][5:2]);
        top = longint'(m_ctrl[ch][31:16]);
        return 32'((m_cyc[ch] >> p) % (top + 1));
    endfunction

    function automatic void m_step();
        int off, ch, p;
        logic wr;
        logic [31:0] opnd, nv;
        logic [N-1:0] fire;
        longint top, c;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                m_ctrl[k] = '0;
                m_cyc[k]  = 0;
            end
            m_int = '0;
            return;
        end
        wr = 1'b0; nv = '0; ch = 0; opnd = '0;
        off = int'(csr_addr) - int'(BASE);
        if (csr_enable && off >= 0 && off < 2 * N && off % 2 == 0) begin
            ch   = off / 2;
            opnd = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
            case (csr_op)
                3'b001, 3'b101: begin wr = 1'b1; nv = opnd; end
                3'b010, 3'b110: begin wr = (opnd != 0); nv = m_ctrl[ch] | opnd; end
                3'b011, 3'b111: begin wr = (opnd != 0); nv = m_ctrl[ch] & ~opnd; end
                default: ;
            endcase
        end
        fire = '0;
        for (int k = 0; k < N; k++) begin
            if (m_ctrl[k][0]) begin
                p   = int'(m_ctrl[k][5:2]);
                top = longint'(m_ctrl[k][31:16]);
                c   = m_cyc[k] + 1;
                m_cyc[k] = c;
                if (c % (longint'(1) << p) == 0 && (c >> p) % (top + 1) == 0) begin
                    fire[k] = 1'b1;
                    if (m_ctrl[k][1]) m_ctrl[k][0] = 1'b0;
                end
            end
        end
        m_int = fire | (m_int & ~interrupt_clear);
        if (wr) begin
            m_ctrl[ch] = nv & CMASK;
            m_cyc[ch]  = 0;
        end
    endfunction

    always @(posedge clk) m_step();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic compare();
        logic [31:0] exp_out = m_read(csr_addr);
        checks++;
        if (csr_out !== exp_out) begin
            errors++;
            $display("FAIL csr_out t=%0t addr=%h act=%h exp=%h", $time, csr_addr, csr_out, exp_out);
        end
        checks++;
        if (interrupt_set !== m_int) begin
            errors++;
            $display("FAIL interrupt_set t=%0t act=%b exp=%b", $time, interrupt_set, m_int);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] data, input logic [4:0] zimm);
        csr_enable = 1'b1; csr_op = op; csr_addr = addr; rs1_data = data; rs1_zimm = zimm;
        step(1);
        csr_enable = 1'b0;
    endtask

    function automatic logic [31:0] rnd_ctrl();
        logic [31:0] v = $urandom;
        v[31:16] = 16'($urandom_range(0, 6));
        v[5:2]   = 4'($urandom_range(0, 2));
        return v;
    endfunction

    initial begin
        step(2);
        chk("reset_ctrl0", csr_out, 32'd0);
        chk("reset_irq", 32'(interrupt_set), 32'd0);
        reset = 1'b1;
        step(1);

        // periodic ch0, top=3, P=0: fires 4, 8, 12 edges after the write
        csr(3'b001, BASE, 32'h0003_0001, 5'd0);
        step(3);  chk("p_e3", 32'(interrupt_set[0]), 32'd0);
        step(1);  chk("p_e4", 32'(interrupt_set[0]), 32'd1);
        interrupt_clear[0] = 1'b1;
        step(1);  chk("p_clr_e5", 32'(interrupt_set[0]), 32'd0);
        interrupt_clear[0] = 1'b0;
        step(2);  chk("p_e7", 32'(interrupt_set[0]), 32'd0);
        step(1);  chk("p_e8", 32'(interrupt_set[0]), 32'd1);
        step(4);  chk("p_e12", 32'(interrupt_set[0]), 32'd1);

        // clear held across a firing edge: set wins
        interrupt_clear[0] = 1'b1;
        csr(3'b001, BASE, 32'h0003_0001, 5'd0);
        chk("w_clr", 32'(interrupt_set[0]), 32'd0);
        step(4);  chk("set_wins", 32'(interrupt_set[0]), 32'd1);
        step(1);  chk("clr_after", 32'(interrupt_set[0]), 32'd0);
        interrupt_clear[0] = 1'b0;
        csr_addr = BASE + 12'd1;
        #1 chk("count_1", csr_out, 32'd1);

        // RSI with zero immediate is a read only: counter keeps going
        csr(3'b110, BASE, 32'hFFFF_FFFF, 5'd0);
        csr_addr = BASE + 12'd1;
        #1 chk("rs0_nowrite", csr_out, 32'd2);
        step(3);
        csr(3'b001, BASE, 32'd0, 5'd0);
        interrupt_clear = '1;
        step(1);
        interrupt_clear = '0;

        // RSI 1 on a disabled channel enables it with top=0: fires every cycle
        csr(3'b110, BASE + 12'd4, 32'd0, 5'd1);
        csr_addr = BASE + 12'd4;
        #1 chk("rsi_ctrl", csr_out, 32'd1);
        chk("rsi_e0", 32'(interrupt_set[2]), 32'd0);
        step(1);  chk("rsi_e1", 32'(interrupt_set[2]), 32'd1);
        csr(3'b001, BASE + 12'd4, 32'd0, 5'd0);
        interrupt_clear = '1;
        step(1);
        interrupt_clear = '0;

        // one-shot ch1, top=2, P=2: single fire 12 edges after the write
        csr(3'b001, BASE + 12'd2, 32'h0002_000B, 5'd0);
        csr_addr = BASE + 12'd2;
        step(11); chk("os_e11", 32'(interrupt_set[1]), 32'd0);
        step(1);  chk("os_e12", 32'(interrupt_set[1]), 32'd1);
        chk("os_ctrl", csr_out, 32'h0002_000A);
        interrupt_clear[1] = 1'b1;
        step(1);
        interrupt_clear[1] = 1'b0;
        step(100); chk("os_quiet", 32'(interrupt_set[1]), 32'd0);

        // past the last channel: reads 0, writes dropped
        csr_addr = BASE + 12'(2 * N);
        #1 chk("oob_read", csr_out, 32'd0);
        csr(3'b001, BASE + 12'(2 * N), 32'hFFFF_FFFF, 5'd0);
        csr_addr = BASE + 12'(2 * N);
        #1 chk("oob_after", csr_out, 32'd0);
        step(5);

        // reset mid-count aborts
        csr(3'b001, BASE + 12'd6, 32'h0005_0001, 5'd0);
        csr_addr = BASE + 12'd7;
        step(2);  chk("rst_cnt2", csr_out, 32'd2);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("rst_irq", 32'(interrupt_set), 32'd0);
        chk("rst_cnt", csr_out, 32'd0);
        csr_addr = BASE + 12'd6;
        #1 chk("rst_ctrl", csr_out, 32'd0);
        step(50); chk("rst_quiet", 32'(interrupt_set), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            csr_enable = ($urandom_range(0, 3) == 0);
            csr_op     = 3'($urandom);
            csr_addr   = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                                                     : BASE + 12'($urandom_range(0, 2 * N + 1));
            rs1_data   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : rnd_ctrl();
            rs1_zimm   = 5'($urandom);
            interrupt_clear = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            reset      = ($urandom_range(0, 499) != 0);
            step(1);
        end
        csr_enable = 1'b0;
        reset = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CounterWidth, default 16, counter/top width in bits (1..16).
REQ-003 SHALL have parameter BaseAddr, default 12'h400, CSR address of channel 0 ctrl register.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port csr_enable  input  1  CSR access valid this cycle.
REQ-007 SHALL have port csr_addr  input  12  CSR address.
REQ-008 SHALL have port csr_op  input  3  RISC-V funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; others no-op.
REQ-009 SHALL have port rs1_zimm  input  5  zero-extended immediate for the I variants.
REQ-010 SHALL have port rs1_data  input  32  register operand for non-I variants.
REQ-011 SHALL have port interrupt_clear  input  NumChannels  per-channel pending-interrupt clear.
REQ-012 SHALL have port interrupt_set  output  NumChannels  per-channel sticky pending interrupt.
REQ-013 SHALL have port csr_out  output  32  combinational read data of the addressed register (pre-write value).

Function
REQ-014 Per channel ch: ctrl at BaseAddr+2*ch, count at BaseAddr+2*ch+1; every other address: csr_out=0, no write.
REQ-015 ctrl layout: bit0 enable; bit1 mode (0 periodic, 1 one-shot); bits[5:2] prescale exponent P; bits[16+CounterWidth-1:16] top; all other bits read 0, writes ignored.
REQ-016 count register: read-only, zero-extended counter value; writes ignored.
REQ-017 RW/RWI write operand; RS/RSI OR; RC/RCI AND-NOT; the RS/RC variants with operand 0 perform no write.
REQ-018 CSR writes take effect at the clock edge ending the access cycle; visible in csr_out the following cycle.
REQ-019 Any write to a channel's ctrl SHALL clear that channel's counter and prescaler the same edge.
REQ-020 Each channel SHALL have a free-running prescaler generating a tick once every 2^P cycles (P=0: every cycle), running only while enable=1.
REQ-021 On a tick with counter != top: counter increments by 1.
REQ-022 On a tick with counter == top: counter <= 0 and interrupt_set[ch] <= 1 on that edge; top=0 fires on every tick.
REQ-023 In one-shot mode the firing edge SHALL also clear enable; periodic mode keeps enable.
REQ-024 interrupt_set[ch] holds until an edge where interrupt_clear[ch]=1 and no fire; simultaneous fire and clear: set wins.
REQ-025 enable=0: counter and prescaler hold, no interrupt generated; interrupt_set unaffected.
REQ-026 Channels SHALL be fully independent; fires on several channels in one cycle all register.
REQ-027 Counter arithmetic is modulo 2^CounterWidth; no out-of-range value occurs since wrap happens at top.
REQ-028 A ctrl write on the same edge as a fire: write wins for ctrl and counter; interrupt still sets.

Reset
REQ-029 With reset=0 at a rising edge: all ctrl=0, counters=0, prescalers=0, interrupt_set=0; CSR writes ignored.
REQ-030 Reset asserted mid-count SHALL abort counting; no interrupt after reset release until re-enabled and top reached.
REQ-031 csr_out remains combinational from current (reset) register state during reset.

Verification
REQ-032 Ch0 ctrl RW 0x0003_0001 (top=3, P=0, periodic) -> interrupt_set[0] rises on edges 4, 8, 12 after the write; clear between fires drops it for 1+ cycles.
REQ-033 Ch1 ctrl top=2, P=2, one-shot, enable -> single fire at edge 12 after write; ctrl bit0 reads 0 afterwards; no further fires over 100 cycles.
REQ-034 interrupt_clear[0]=1 held on a firing edge -> interrupt_set[0]=1 afterward; clear next cycle -> 0.
REQ-035 RS with rs1_zimm=0 to ch0 ctrl mid-count -> counter not reset; RSI 1 to disabled channel -> enables and resets counter to 0.
REQ-036 Read BaseAddr+2*NumChannels -> csr_out=0; write there -> no channel state changes.
REQ-037 reset=0 for one edge during count=2 of top=5 -> all outputs 0, ctrl reads 0, no interrupt for 50 cycles.
